// File: rtl/cgra_cfg_loader.sv
// CGRA configuration loader: parses a header word from the DMA stream, then
// pairs 32-bit words into 64-bit context frames written to one or all tiles.
//
// state | meaning
// IDLE  | waiting for a header word
// LO    | header accepted, waiting for the low word of the next frame
// HI    | low word held, waiting for the high word; its arrival writes the frame
module cgra_cfg_loader #(
   parameter int NUM_TILES = 16,
   parameter int PC_WIDTH  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic [31:0]          s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   output logic [NUM_TILES-1:0] cfg_wr_en,
   output logic [PC_WIDTH-1:0]  cfg_wr_addr,
   output logic [63:0]          cfg_wr_data,
   output logic                 busy,
   output logic                 done,
   output logic                 hdr_err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LO   = 2'd1;
   localparam logic [1:0] HI   = 2'd2;

   localparam logic [8:0] NT = 9'(NUM_TILES);

   logic [1:0]           state_q, state_d;
   logic [NUM_TILES-1:0] mask_q, mask_d;
   logic [PC_WIDTH-1:0]  pc_q, pc_d;
   logic [7:0]           rem_q, rem_d;
   logic [31:0]          lo_word_q, lo_word_d;
   logic [NUM_TILES-1:0] cfg_wr_en_q, cfg_wr_en_d;
   logic [PC_WIDTH-1:0]  cfg_wr_addr_q, cfg_wr_addr_d;
   logic [63:0]          cfg_wr_data_q, cfg_wr_data_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 hdr_err_q, hdr_err_d;

   logic [7:0]           hdr_tile;
   logic [7:0]           hdr_cnt;
   logic [PC_WIDTH-1:0]  hdr_pc;
   logic                 hdr_bcast;
   logic                 hdr_ok;
   logic [NUM_TILES-1:0] hdr_mask;
   logic                 xfer;

   assign s_ready = !clear;
   assign xfer    = s_valid && !clear;

   assign hdr_tile  = s_data[23:16];
   assign hdr_pc    = s_data[12 +: PC_WIDTH];
   assign hdr_cnt   = s_data[7:0];
   assign hdr_bcast = (hdr_tile == 8'hFF);
   assign hdr_ok    = (s_data[31:28] == 4'hC) && (({1'b0, hdr_tile} < NT) || hdr_bcast);

   always_comb begin
      hdr_mask = '0;
      for (int i = 0; i < NUM_TILES; i++) begin
         hdr_mask[i] = hdr_bcast || (hdr_tile == 8'(i));
      end
   end

   always_comb begin
      state_d       = state_q;
      mask_d        = mask_q;
      pc_d          = pc_q;
      rem_d         = rem_q;
      lo_word_d     = lo_word_q;
      cfg_wr_en_d   = '0;
      cfg_wr_addr_d = cfg_wr_addr_q;
      cfg_wr_data_d = cfg_wr_data_q;
      done_d        = 1'b0;
      hdr_err_d     = 1'b0;

      if (clear) begin
         state_d = IDLE;
      end else if (xfer) begin
         case (state_q)
            IDLE: begin
               if (!hdr_ok) begin
                  hdr_err_d = 1'b1;
               end else if (hdr_cnt == 8'd0) begin
                  done_d = 1'b1;
               end else begin
                  mask_d  = hdr_mask;
                  pc_d    = hdr_pc;
                  rem_d   = hdr_cnt;
                  state_d = LO;
               end
            end
            LO: begin
               lo_word_d = s_data;
               state_d   = HI;
            end
            HI: begin
               cfg_wr_en_d   = mask_q;
               cfg_wr_addr_d = pc_q;
               cfg_wr_data_d = {s_data, lo_word_q};
               pc_d          = pc_q + PC_WIDTH'(1);
               rem_d         = rem_q - 8'd1;
               if (rem_q == 8'd1) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = LO;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         mask_q        <= '0;
         pc_q          <= '0;
         rem_q         <= '0;
         lo_word_q     <= '0;
         cfg_wr_en_q   <= '0;
         cfg_wr_addr_q <= '0;
         cfg_wr_data_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         hdr_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         mask_q        <= mask_d;
         pc_q          <= pc_d;
         rem_q         <= rem_d;
         lo_word_q     <= lo_word_d;
         cfg_wr_en_q   <= cfg_wr_en_d;
         cfg_wr_addr_q <= cfg_wr_addr_d;
         cfg_wr_data_q <= cfg_wr_data_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         hdr_err_q     <= hdr_err_d;
      end
   end

   assign cfg_wr_en   = cfg_wr_en_q;
   assign cfg_wr_addr = cfg_wr_addr_q;
   assign cfg_wr_data = cfg_wr_data_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign hdr_err     = hdr_err_q;

endmodule

// File: tb/tb_cgra_cfg_loader.sv
// Scoreboard bench for cgra_cfg_loader: stimulus pushes expected output
// events, an independent monitor pops them whenever the DUT emits one.
module tb_cgra_cfg_loader;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] cfg_wr_en;
   logic [3:0]  cfg_wr_addr;
   logic [63:0] cfg_wr_data;
   logic        busy;
   logic        done;
   logic        hdr_err;

   cgra_cfg_loader #(.NUM_TILES(16), .PC_WIDTH(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .cfg_wr_en   (cfg_wr_en),
      .cfg_wr_addr (cfg_wr_addr),
      .cfg_wr_data (cfg_wr_data),
      .busy        (busy),
      .done        (done),
      .hdr_err     (hdr_err)
   );

   typedef struct {
      logic [15:0] en;
      logic [3:0]  addr;
      logic [63:0] data;
      logic        done;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Drive one word after an optional idle gap; returns 1ns after the accepting edge.
   task automatic send(input logic [31:0] w, input int gap);
      s_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      s_valid = 1'b1;
      s_data  = w;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic push(input logic [15:0] en, input logic [3:0] addr, input logic [63:0] data,
                       input logic dn, input logic er);
      exp_t e;
      e.en = en; e.addr = addr; e.data = data; e.done = dn; e.err = er; e.cyc = cyc;
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && ((|cfg_wr_en) || done || hdr_err)) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: en=%h addr=%h done=%b hdr_err=%b required none",
                        cfg_wr_en, cfg_wr_addr, done, hdr_err);
            end else begin
               e = exp_q.pop_front();
               check("wr_en",   64'(cfg_wr_en), 64'(e.en));
               check("done",    64'(done),      64'(e.done));
               check("hdr_err", 64'(hdr_err),   64'(e.err));
               check("latency", 64'(cyc),       64'(e.cyc));
               if (e.en != 16'h0) begin
                  check("wr_addr", 64'(cfg_wr_addr), 64'(e.addr));
                  check("wr_data", cfg_wr_data,      e.data);
               end
            end
         end
      end
   end

   initial begin : stim
      logic [31:0] w0, w1;
      rst_n   = 1'b0;
      clear   = 1'b0;
      s_valid = 1'b0;
      s_data  = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_s_ready", 64'(s_ready),     64'd1);
      check("rst_wr_en",   64'(cfg_wr_en),   64'd0);
      check("rst_wr_addr", 64'(cfg_wr_addr), 64'd0);
      check("rst_wr_data", cfg_wr_data,      64'd0);
      check("rst_busy",    64'(busy),        64'd0);
      check("rst_done",    64'(done),        64'd0);
      check("rst_hdr_err", 64'(hdr_err),     64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // tile 3, pc 2, two frames
      send(32'hC003_2002, 0);
      check("busy_after_hdr", 64'(busy), 64'd1);
      send(32'hA000_0000, 0);
      send(32'hA111_1111, 0);
      push(16'h0008, 4'h2, 64'hA111_1111_A000_0000, 1'b0, 1'b0);
      send(32'hB000_0000, 0);
      send(32'hB111_1111, 0);
      push(16'h0008, 4'h3, 64'hB111_1111_B000_0000, 1'b1, 1'b0);

      // broadcast, pc 15 wrapping to 0 and 1, three frames, back-to-back header
      send(32'hC0FF_F003, 0);
      send(32'hC000_0000, 0);
      send(32'hC100_0000, 0);
      push(16'hFFFF, 4'hF, 64'hC100_0000_C000_0000, 1'b0, 1'b0);
      send(32'hC000_0001, 0);
      send(32'hC100_0001, 0);
      push(16'hFFFF, 4'h0, 64'hC100_0001_C000_0001, 1'b0, 1'b0);
      send(32'hC000_0002, 0);
      send(32'hC100_0002, 0);
      push(16'hFFFF, 4'h1, 64'hC100_0002_C000_0002, 1'b1, 1'b0);
      check("busy_after_last_hi", 64'(busy), 64'd0);

      // rejected headers
      send(32'hB003_0001, 0);
      push(16'h0, 4'h0, 64'h0, 1'b0, 1'b1);
      check("busy_bad_magic", 64'(busy), 64'd0);
      send(32'hC020_0001, 0);
      push(16'h0, 4'h0, 64'h0, 1'b0, 1'b1);
      check("busy_bad_tile", 64'(busy), 64'd0);

      // zero-count header
      send(32'hC001_0000, 0);
      push(16'h0, 4'h0, 64'h0, 1'b1, 1'b0);
      check("busy_zero_cnt", 64'(busy), 64'd0);

      // tile 7, pc 4, four frames: first gap-free, then with random gaps
      for (int pass = 0; pass < 2; pass++) begin
         send(32'hC007_4004, (pass == 1) ? int'($urandom_range(0, 5)) : 0);
         for (int i = 0; i < 4; i++) begin
            w0 = 32'h1000_0000 + 32'(i);
            w1 = 32'h2000_0000 + 32'(i);
            send(w0, (pass == 1) ? int'($urandom_range(0, 5)) : 0);
            send(w1, (pass == 1) ? int'($urandom_range(0, 5)) : 0);
            push(16'h0080, 4'(4 + i), {w1, w0}, (i == 3), 1'b0);
         end
      end

      // clear after a LO word drops the partial frame
      send(32'hC005_0001, 0);
      send(32'h5555_0000, 0);
      clear   = 1'b1;
      s_valid = 1'b1;
      s_data  = 32'hDEAD_BEEF;
      #1;
      check("s_ready_during_clear", 64'(s_ready), 64'd0);
      @(posedge clk);
      #1;
      clear   = 1'b0;
      s_valid = 1'b0;
      check("busy_after_clear", 64'(busy), 64'd0);
      send(32'hC005_0001, 1);
      send(32'h5A5A_0000, 0);
      send(32'h5A5A_1111, 0);
      push(16'h0020, 4'h0, 64'h5A5A_1111_5A5A_0000, 1'b1, 1'b0);

      // reset mid-frame abandons the frame
      send(32'hC005_0001, 0);
      send(32'h6666_0000, 0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst_mid_wr_en", 64'(cfg_wr_en), 64'd0);
      check("rst_mid_busy",  64'(busy),      64'd0);
      rst_n = 1'b1;
      send(32'hC005_0001, 1);
      send(32'h7777_0000, 0);
      send(32'h7777_1111, 0);
      push(16'h0020, 4'h0, 64'h7777_1111_7777_0000, 1'b1, 1'b0);

      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cgra_cfg_loader.md
# cgra_cfg_loader

Configuration loader that sits directly upstream of every CGRA tile's config write port (`cfg_wr_addr` / `cfg_wr_data` / `cfg_wr_en`).
- Consumes a 32-bit word stream from the DMA with a valid/ready handshake.
- Parses a header word, then assembles pairs of words into 64-bit context frames.
- Writes each frame into consecutive context slots of one tile, or of all tiles (broadcast).
- Outputs are registered and fan out to all tiles; each tile has its own write enable.

## Interface
- `NUM_TILES`, 16, number of tiles driven; maximum 255.
- `PC_WIDTH`, 4, context address width; context slots are 2^PC_WIDTH.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `clear`  in  1  synchronous soft abort; returns the block to IDLE and drops any partial frame.
- `s_data`  in  32  DMA stream word.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  loader accepts a word this cycle.
- `cfg_wr_en`  out  NUM_TILES  one-hot (or all-ones when broadcast) per-tile write strobe, one cycle per frame.
- `cfg_wr_addr`  out  PC_WIDTH  context slot being written.
- `cfg_wr_data`  out  64  frame being written: `{hi_word, lo_word}`.
- `busy`  out  1  a header has been accepted and its frames are not all received.
- `done`  out  1  one-cycle pulse when a header's last frame is written, or when a zero-count header is accepted.
- `hdr_err`  out  1  one-cycle pulse when a header word is rejected.

## Operation
- **Handshake.** A word transfers when `s_valid && s_ready`.
  - `s_ready` = !`clear` in every state. The loader never back-pressures otherwise, so throughput is 1 word/cycle.
- **Header word.**
  - [31:28] magic, must be 4'hC.
  - [23:16] tile id; 8'hFF means broadcast.
  - [15:12] start pc; the low PC_WIDTH bits are used.
  - [7:0] frame count N.
  - Other bits are ignored.
- **Header validity.** A header is valid iff the magic is 4'hC and (tile id < NUM_TILES or tile id == 8'hFF).
  - Invalid header: `hdr_err` pulses the next cycle, the word is dropped, and the state stays IDLE.
- **FSM states: IDLE, LO, HI.**
  - IDLE + valid header, N>0: latch tile select, pc = start pc, and remaining = N; go to LO.
  - IDLE + valid header, N=0: `done` pulses next cycle; stay IDLE.
  - LO + word: latch `lo_word`; go to HI.
  - HI + word: register `cfg_wr_data` = {word, `lo_word`}, `cfg_wr_addr` = pc, and `cfg_wr_en` = tile mask.
    - pc increments modulo 2^PC_WIDTH (wraps from 4'hF to 4'h0); remaining decrements.
    - If remaining was 1: `done` is registered, go to IDLE. Otherwise go to LO.
- **Tile mask.** Bit `tile_id` is set, or all NUM_TILES bits when broadcast.
- **N > 2^PC_WIDTH** is legal: the address wraps and later frames overwrite earlier slots.
- **`clear`.** Takes priority over any stream word (no transfer occurs that cycle). Next state is IDLE, and the partial `lo_word` is discarded.
  - A `cfg_wr_en` pulse already registered still completes. No `done` or `hdr_err` is generated by `clear`.
- **`busy`** = (state != IDLE), registered.

## Timing
- **Reset values:** `s_ready`=1, `cfg_wr_en`=0, `cfg_wr_addr`=0, `cfg_wr_data`=0, `busy`=0, `done`=0, `hdr_err`=0, state IDLE.
  - Reset mid-frame abandons the frame with no write.
- **Write latency:** HI word accepted at edge t gives `cfg_wr_en` high for exactly the cycle after edge t, with address and data valid in that same cycle.
  - `cfg_wr_addr` and `cfg_wr_data` hold their values until the next write. `cfg_wr_en` is low in all other cycles.
- **`done`:** high in the same cycle as the last frame's `cfg_wr_en`. For an N=0 header it is high in the cycle after the header is accepted.
- **Back-to-back headers:** a new header may arrive in the cycle right after the last HI word. Its own `done` or `hdr_err` appears one cycle later.
- **Minimum load time:** N frames take 1 + 2N accepted words. Frames are written back-to-back every 2 cycles at full rate.
- **Gaps in `s_valid`:** state holds and no output changes other than the `cfg_wr_en` / `done` / `hdr_err` pulses deasserting.

## Test plan
- Header 32'hC003_2002 (tile 3, pc 2, N=2), then words A0,A1,B0,B1 back-to-back:
  - `cfg_wr_en`=16'h0008 at addr 2 with data {A1,A0}.
  - Then at addr 3 with data {B1,B0}, and `done` in the same cycle as the second write.
- Broadcast header 32'hC0FF_F003 (pc 15, N=3):
  - Writes go to addresses 15, 0, 1 with `cfg_wr_en`=16'hFFFF.
  - `busy` is low the cycle after the third HI word.
- Header 32'hB003_0001 (bad magic) and 32'hC020_0001 (tile 32 ≥ 16):
  - Each gives an `hdr_err` pulse, with no writes and `busy`=0.
- Header 32'hC001_0000 (N=0): `done` pulses the next cycle, with no `cfg_wr_en`.
- Random `s_valid` gaps of 0–5 cycles during a 4-frame load: writes are identical to the gap-free run, and each write appears 1 cycle after its HI word.
- `clear` asserted after a LO word, then separately `rst_n` pulsed mid-frame:
  - No write occurs and `s_ready` is low during the `clear` cycle.
  - Afterwards a fresh header 32'hC005_0001 with a 2-word frame writes tile 5, addr 0.
